// File: rtl/bpu_btb_pkg.sv
// Shared types and constants for the branch target buffer.
// Holds the per-cycle update classification and counter seed values.
// Imported by the top and by the saturating counter.
package bpu_btb_pkg;

  // What the EX-stage resolve does to the BTB entry at its index this cycle.
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_ALLOC = 2'd2,
    UPD_INVAL = 2'd3
  } upd_kind_e;

  // Counter value after reset: weakly not-taken.
  function automatic int cnt_init_val(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  // Counter value on a fresh allocation: weakly taken.
  function automatic int cnt_alloc_val(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/bpu_btb_sat_counter.sv
// Per-entry saturating direction counter; MSB is the taken prediction.
// Latency: value updates on the rising edge after load/en.
// No backpressure: load has priority over a training step.
module bpu_btb_sat_counter
  import bpu_btb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_init_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_alloc_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next value: reseed on allocation, otherwise step toward the outcome and stick at the ends.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_ALLOC;
    end else if (en_i) begin
      if (taken_i) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= CNT_INIT;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry saturating counters: IF lookup, EX resolve/train.
// Latency: lookup and resolve are combinational; training lands on the next rising edge.
// No backpressure: one lookup and one update every cycle; lookup never sees same-cycle training.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PC_LSB  = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_tgt,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - PC_LSB - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic             jmp_q   [ENTRIES];
  logic [CNT_W-1:0] cnt     [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_ctrl;
  logic [XLEN-1:0]  act_next;
  upd_kind_e        upd_kind;

  logic [STAT_W-1:0] stat_br_q;
  logic [STAT_W-1:0] stat_br_d;
  logic [STAT_W-1:0] stat_mp_q;
  logic [STAT_W-1:0] stat_mp_d;

  assign l_idx  = lookup_pc[PC_LSB +: IDX_W];
  assign l_tag  = lookup_pc[XLEN-1 -: TAG_W];
  assign u_idx  = upd_pc[PC_LSB +: IDX_W];
  assign u_tag  = upd_pc[XLEN-1 -: TAG_W];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctrl = upd_is_branch || upd_is_jump;

  // Fetch-side prediction from the pre-edge table contents.
  always_comb begin
    pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && (jmp_q[l_idx] || cnt[l_idx][CNT_W-1]);
    pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + XLEN'(4);
  end

  // Resolve: compare the true next PC against what fetch assumed.
  always_comb begin
    act_next    = upd_taken ? upd_target : upd_pc + XLEN'(4);
    mispredict  = upd_valid && (act_next != upd_pred_tgt);
    redirect_pc = act_next;
  end

  // Classify the update; a flush suppresses all training for the cycle.
  always_comb begin
    upd_kind = UPD_NONE;
    if (upd_valid && !flush_all) begin
      if (u_ctrl) begin
        if (u_hit)          upd_kind = UPD_TRAIN;
        else if (upd_taken) upd_kind = UPD_ALLOC;
      end else if (upd_pred_taken && u_hit) begin
        // A non-control instruction aliased onto a taken entry: drop that entry.
        upd_kind = UPD_INVAL;
      end
    end
  end

  // Entry valid/tag/target/type storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        jmp_q[i]   <= 1'b0;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else begin
      case (upd_kind)
        UPD_TRAIN: begin
          if (upd_taken) tgt_q[u_idx] <= upd_target;
          jmp_q[u_idx] <= upd_is_jump;
        end
        UPD_ALLOC: begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= upd_target;
          jmp_q[u_idx]   <= upd_is_jump;
        end
        UPD_INVAL: valid_q[u_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    bpu_btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load_i  ((upd_kind == UPD_ALLOC) && (u_idx == IDX_W'(i))),
      .en_i    ((upd_kind == UPD_TRAIN) && (u_idx == IDX_W'(i))),
      .taken_i (upd_taken),
      .cnt_o   (cnt[i])
    );
  end

  // Statistics next-state: count up and stick at all-ones.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid && u_ctrl && (stat_br_q != {STAT_W{1'b1}})) stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict && (stat_mp_q != {STAT_W{1'b1}}))          stat_mp_d = stat_mp_q + STAT_W'(1);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboard bench for bpu_btb (STAT_W=4 so counter saturation is reachable).
// Driver sets inputs after each rising edge and queues the expected outputs;
// a monitor on the falling edge pops and compares.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_tgt;
  logic        flush_all;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  stat_branches, stat_mispred;

  always #5 clk = ~clk;

  bpu_btb #(.STAT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_branch  (upd_is_branch),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_tgt   (upd_pred_tgt),
    .flush_all      (flush_all),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  typedef struct {
    int          id;
    logic        hit;
    logic        tkn;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] red;
    logic [3:0]  sb;
    logic [3:0]  sm;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step   = 0;

  task automatic cmp(input int id, input string what, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", id, what, got, want);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.id, "pred_hit",      {31'b0, pred_hit},      {31'b0, e.hit});
        cmp(e.id, "pred_taken",    {31'b0, pred_taken},    {31'b0, e.tkn});
        cmp(e.id, "pred_target",   pred_target,            e.tgt);
        cmp(e.id, "mispredict",    {31'b0, mispredict},    {31'b0, e.mis});
        if (e.mis) cmp(e.id, "redirect_pc", redirect_pc, e.red);
        cmp(e.id, "stat_branches", {28'b0, stat_branches}, {28'b0, e.sb});
        cmp(e.id, "stat_mispred",  {28'b0, stat_mispred},  {28'b0, e.sm});
      end
    end
  end

  task automatic upd(input logic [31:0] pc, input logic br, input logic jp, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_branch  = br;
    upd_is_jump    = jp;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = ptk;
    upd_pred_tgt   = ptgt;
  endtask

  task automatic idle();
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_is_branch  = 1'b0;
    upd_is_jump    = 1'b0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_pred_taken = 1'b0;
    upd_pred_tgt   = '0;
  endtask

  // Apply lookup_pc, queue the expected outputs for this cycle, then advance one clock.
  task automatic ex(input logic [31:0] lpc, input logic hit, input logic tkn, input logic [31:0] ptgt,
                    input logic mis, input logic [31:0] red, input logic [3:0] sb, input logic [3:0] sm);
    exp_t e;
    lookup_pc = lpc;
    step++;
    e.id = step; e.hit = hit; e.tkn = tkn; e.tgt = ptgt;
    e.mis = mis; e.red = red; e.sb = sb; e.sm = sm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    flush_all = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    flush_all = 1'b0;
    lookup_pc = 32'h100;
    idle();
    @(posedge clk);
    #1;
    // Held in reset.
    ex(32'h100, 0, 0, 32'h104, 0, 0, 0, 0);
    rst = 1'b1;

    // 1: empty table after reset.
    ex(32'h100, 0, 0, 32'h104, 0, 0, 0, 0);

    // 2: first taken branch allocates; same-cycle lookup still misses.
    upd(32'h100, 1, 0, 1, 32'h080, 0, 32'h104);
    ex(32'h100, 0, 0, 32'h104, 1, 32'h080, 0, 0);
    ex(32'h100, 1, 1, 32'h080, 0, 0, 1, 1);

    // 3: not-taken twice (2->1->0), once more holds at 0.
    upd(32'h100, 1, 0, 0, 32'h080, 1, 32'h080);
    ex(32'h100, 1, 1, 32'h080, 1, 32'h104, 1, 1);
    ex(32'h100, 1, 0, 32'h104, 0, 0, 2, 2);
    upd(32'h100, 1, 0, 0, 32'h080, 0, 32'h104);
    ex(32'h100, 1, 0, 32'h104, 0, 0, 2, 2);
    upd(32'h100, 1, 0, 0, 32'h080, 0, 32'h104);
    ex(32'h100, 1, 0, 32'h104, 0, 0, 3, 2);
    // Four taken: 0->1->2->3->3.
    upd(32'h100, 1, 0, 1, 32'h080, 0, 32'h104);
    ex(32'h100, 1, 0, 32'h104, 1, 32'h080, 4, 2);
    upd(32'h100, 1, 0, 1, 32'h080, 0, 32'h104);
    ex(32'h100, 1, 0, 32'h104, 1, 32'h080, 5, 3);
    upd(32'h100, 1, 0, 1, 32'h080, 1, 32'h080);
    ex(32'h100, 1, 1, 32'h080, 0, 0, 6, 4);
    upd(32'h100, 1, 0, 1, 32'h080, 1, 32'h080);
    ex(32'h100, 1, 1, 32'h080, 0, 0, 7, 4);
    // One not-taken from saturation (3->2) still predicts taken.
    upd(32'h100, 1, 0, 0, 32'h080, 1, 32'h080);
    ex(32'h100, 1, 1, 32'h080, 1, 32'h104, 8, 4);
    ex(32'h100, 1, 1, 32'h080, 0, 0, 9, 5);

    // 4: 0x140 shares index 0 and evicts 0x100.
    upd(32'h140, 1, 0, 1, 32'h300, 0, 32'h144);
    ex(32'h100, 1, 1, 32'h080, 1, 32'h300, 9, 5);
    ex(32'h100, 0, 0, 32'h104, 0, 0, 10, 6);
    ex(32'h140, 1, 1, 32'h300, 0, 0, 10, 6);

    // 5: jump at 0x200, later resolved as an ALU op.
    upd(32'h200, 0, 1, 1, 32'h400, 0, 32'h204);
    ex(32'h200, 0, 0, 32'h204, 1, 32'h400, 10, 6);
    ex(32'h200, 1, 1, 32'h400, 0, 0, 11, 7);
    upd(32'h200, 0, 0, 0, 32'h000, 1, 32'h400);
    ex(32'h200, 1, 1, 32'h400, 1, 32'h204, 11, 7);
    ex(32'h200, 0, 0, 32'h204, 0, 0, 11, 8);

    // Invalid update slot: no mispredict, no training.
    upd(32'h500, 1, 0, 1, 32'h900, 0, 32'h000);
    upd_valid = 1'b0;
    ex(32'h500, 0, 0, 32'h504, 0, 0, 11, 8);
    ex(32'h500, 0, 0, 32'h504, 0, 0, 11, 8);

    // 6: flush_all beats a same-cycle allocation; mispredict still reported.
    upd(32'h104, 0, 1, 1, 32'h600, 0, 32'h108);
    ex(32'h104, 0, 0, 32'h108, 1, 32'h600, 11, 8);
    ex(32'h104, 1, 1, 32'h600, 0, 0, 12, 9);
    upd(32'h208, 1, 0, 1, 32'h700, 0, 32'h20C);
    flush_all = 1'b1;
    ex(32'h104, 1, 1, 32'h600, 1, 32'h700, 12, 9);
    ex(32'h104, 0, 0, 32'h108, 0, 0, 13, 10);
    ex(32'h208, 0, 0, 32'h20C, 0, 0, 13, 10);

    // stat_mispred climbs to all-ones and holds.
    for (int i = 0; i < 7; i++) begin
      upd(32'h800, 0, 0, 0, 32'h000, 1, 32'h900);
      ex(32'h800, 0, 0, 32'h804, 1, 32'h804, 13, ((10 + i) > 15) ? 4'd15 : 4'(10 + i));
    end
    // stat_branches climbs to all-ones and holds (correct not-taken misses).
    for (int i = 0; i < 4; i++) begin
      upd(32'h900, 1, 0, 0, 32'h000, 0, 32'h904);
      ex(32'h900, 0, 0, 32'h904, 0, 0, ((13 + i) > 15) ? 4'd15 : 4'(13 + i), 15);
    end
    ex(32'h900, 0, 0, 32'h904, 0, 0, 15, 15);

    // Reset mid-operation clears table and statistics at once.
    upd(32'hA00, 0, 1, 1, 32'hB00, 0, 32'hA04);
    ex(32'hA00, 0, 0, 32'hA04, 1, 32'hB00, 15, 15);
    ex(32'hA00, 1, 1, 32'hB00, 0, 0, 15, 15);
    rst = 1'b0;
    ex(32'hA00, 0, 0, 32'hA04, 0, 0, 0, 0);
    rst = 1'b1;
    ex(32'hA00, 0, 0, 32'hA04, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
